// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO switch-input path: default sizes and the
// per-bit debounce state encoding.
package gpio_pkg;

  localparam int GPIO_WIDTH        = 8;
  localparam int DB_CYCLES_DEFAULT = 500000;

  // STABLE: synchronised input agrees with the accepted level.
  // PENDING: it disagrees and the hold counter is running.
  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_t;

  // Counter width able to represent 0..cycles.
  function automatic int db_count_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, hold counter with a STABLE/PENDING
// FSM, and registered rise/fall pulses aligned with the accepted level change.
module debounce_bit
  import gpio_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic mclk,
  input  logic reset,
  input  logic sw_i,
  output logic sw_o,
  output logic rise_o,
  output logic fall_o,
  output logic accept
);

  localparam int             CW   = db_count_width(DB_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  db_state_t     state;
  logic          sw_next;

  // The state register always mirrors (s2 != sw_o), so acceptance fires on
  // the edge where the new level has been seen for DB_CYCLES pending edges.
  assign accept  = (state == PENDING) && (cnt == LAST);
  assign sw_next = accept ? s2 : sw_o;

  // Two-flop synchroniser for the asynchronous board switch level.
  always_ff @(posedge mclk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw_i;
      s2 <= s1;
    end
  end

  // Debounce FSM: count while pending, accept at the last count, and clear
  // the count as soon as the input falls back to the accepted level.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state  <= STABLE;
      cnt    <= '0;
      sw_o   <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sw_o   <= sw_next;
      rise_o <= accept & s2;
      fall_o <= accept & ~s2;
      state  <= (s1 != sw_next) ? PENDING : STABLE;
      case (state)
        STABLE:  cnt <= '0;
        PENDING: cnt <= accept ? '0 : cnt + CW'(1);
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/gpio_in_debounce.sv
// Debounced GPIO switch input: WIDTH independent debounce_bit instances plus
// a registered "any bit changed" pulse.
module gpio_in_debounce
  import gpio_pkg::*;
#(
  parameter int WIDTH     = GPIO_WIDTH,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             chg_o
);

  logic [WIDTH-1:0] accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DB_CYCLES (DB_CYCLES)
    ) u_bit (
      .mclk   (mclk),
      .reset  (reset),
      .sw_i   (sw_i[i]),
      .sw_o   (sw_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i]),
      .accept (accept[i])
    );
  end

  // Register the OR of per-bit acceptances so chg_o lines up with rise/fall.
  always_ff @(posedge mclk) begin
    if (reset) begin
      chg_o <= 1'b0;
    end else begin
      chg_o <= |accept;
    end
  end

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Scoreboard bench for gpio_in_debounce with DB_CYCLES=4: stimulus pushes the
// expected change events, a negedge monitor pops and compares them.
module tb_gpio_in_debounce;

  localparam int WIDTH = 8;
  localparam int DB    = 4;

  logic             mclk  = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] sw_i  = '0;
  logic [WIDTH-1:0] sw_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic             chg_o;

  gpio_in_debounce #(
    .WIDTH     (WIDTH),
    .DB_CYCLES (DB)
  ) dut (
    .mclk   (mclk),
    .reset  (reset),
    .sw_i   (sw_i),
    .sw_o   (sw_o),
    .rise_o (rise_o),
    .fall_o (fall_o),
    .chg_o  (chg_o)
  );

  typedef struct {
    int               at_edge;
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
  } exp_t;

  exp_t             exp_q[$];
  int               checks    = 0;
  int               errors    = 0;
  int               edge_n    = 0;
  logic             rst_seen  = 1'b0;
  logic [WIDTH-1:0] exp_sw    = '0;
  logic [WIDTH-1:0] lvl       = '0;
  bit               done      = 1'b0;

  // 100 MHz-style free-running clock.
  always #5 mclk = ~mclk;

  // Edge counter and the reset level seen at each edge.
  always @(posedge mclk) begin
    edge_n   <= edge_n + 1;
    rst_seen <= reset;
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0h, required %0h",
               name, edge_n, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  // Drive a new level held from now; s1 samples it on the next edge, so the
  // accepted change lands 1 + 1 + DB edges after the current edge.
  task automatic apply_stimulus(input logic [WIDTH-1:0] v);
    exp_t e;
    sw_i = v;
    if (v != lvl) begin
      e.at_edge = edge_n + 6;
      e.sw      = v;
      e.rise    = v & ~lvl;
      e.fall    = lvl & ~v;
      exp_q.push_back(e);
    end
    lvl = v;
  endtask

  // Monitor: reset cycles must be all-zero, any pulse must match the next
  // scoreboard entry, and quiet cycles must hold the last accepted level.
  always @(negedge mclk) begin
    exp_t e;
    if (edge_n > 0 && !done) begin
      if (rst_seen) begin
        check_output("reset_outputs", 32'({sw_o, rise_o, fall_o, chg_o}), 32'd0);
        exp_sw = '0;
      end else if (chg_o !== 1'b0 || rise_o !== '0 || fall_o !== '0) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_event", 32'({rise_o, fall_o, chg_o}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("event_edge", 32'(edge_n), 32'(e.at_edge));
          check_output("event_sw_o", 32'(sw_o), 32'(e.sw));
          check_output("event_rise_o", 32'(rise_o), 32'(e.rise));
          check_output("event_fall_o", 32'(fall_o), 32'(e.fall));
          check_output("event_chg_o", 32'(chg_o), 32'd1);
          exp_sw = e.sw;
        end
      end else begin
        check_output("sw_o_steady", 32'(sw_o), 32'(exp_sw));
      end
    end
  end

  initial begin
    int   e0;
    exp_t e;
    logic [7:0] bounce;

    // Reset for three edges.
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Single bit rise then fall.
    apply_stimulus(8'h01);
    tick(10);
    apply_stimulus(8'h00);
    tick(10);

    // Three-cycle glitch on bit 0 must be rejected.
    sw_i = 8'h01;
    tick(3);
    sw_i = 8'h00;
    tick(12);

    // Bounce on bit 2: accepted once four consecutive highs reach s2.
    bounce = 8'b1111_0111;
    e0 = edge_n;
    e.at_edge = e0 + 10;
    e.sw      = 8'h04;
    e.rise    = 8'h04;
    e.fall    = 8'h00;
    exp_q.push_back(e);
    lvl = 8'h04;
    for (int i = 0; i < 8; i++) begin
      sw_i[2] = bounce[i];
      tick(1);
    end
    tick(10);
    apply_stimulus(8'h00);
    tick(10);

    // Two bits rise together, then one falls twenty edges later.
    apply_stimulus(8'h81);
    tick(20);
    apply_stimulus(8'h80);
    tick(10);

    // All high, reset mid-count aborts it; recount from first post-reset edge.
    sw_i = 8'hFF;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    lvl = 8'h00;
    apply_stimulus(8'hFF);
    tick(12);

    // All bits fall together: one chg_o pulse with fall_o=0xFF.
    apply_stimulus(8'h00);
    tick(12);

    done = 1'b1;
    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_in_debounce.md
GPIO_IN_DEBOUNCE -- requirements
Module: gpio_in_debounce

Interface
REQ-001 Parameter WIDTH, default 8, number of switch bits handled.
REQ-002 Parameter DB_CYCLES, default 500000, consecutive mclk cycles a bit must hold before acceptance (10 ms at 50 MHz); legal range is 1 or more.
REQ-003 mclk  input  1  system clock (50 MHz board clock); all flops clock on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sw_i  input  WIDTH  raw asynchronous board switch levels.
REQ-006 sw_o  output  WIDTH  debounced, synchronised switch levels; feeds the processor GPIO input port.
REQ-007 rise_o  output  WIDTH  per-bit one-cycle pulse when the sw_o bit goes 0->1.
REQ-008 fall_o  output  WIDTH  per-bit one-cycle pulse when the sw_o bit goes 1->0.
REQ-009 chg_o  output  1  one-cycle pulse when any sw_o bit changes.

Function
REQ-010 Each sw_i bit SHALL pass a two-flop synchroniser (s1, s2) before any other use.
REQ-011 Each bit SHALL own a counter of width clog2(DB_CYCLES+1) and a two-state FSM: STABLE (s2 == sw_o bit) and PENDING (s2 != sw_o bit).
REQ-012 In STABLE, the counter SHALL be held at 0.
REQ-013 In PENDING with counter < DB_CYCLES-1, the counter SHALL increment by 1 per edge.
REQ-014 In PENDING with counter == DB_CYCLES-1, the edge SHALL load sw_o bit <= s2, clear the counter and return to STABLE.
REQ-015 If s2 returns equal to sw_o before acceptance, the counter SHALL clear on that edge with no output change (glitch rejection).
REQ-016 For a new sw_i level first sampled by s1 at edge k and held, sw_o SHALL change exactly at edge k+1+DB_CYCLES.
REQ-017 rise_o/fall_o bits SHALL be registered and asserted in the same cycle sw_o changes, for exactly one cycle.
REQ-018 chg_o SHALL be registered and SHALL equal the OR of all rise_o and fall_o bits in the same cycle.
REQ-019 Bits SHALL be fully independent; simultaneous acceptance on several bits SHALL produce one chg_o pulse with all corresponding rise_o/fall_o bits set.
REQ-020 The counter SHALL never exceed DB_CYCLES-1 and SHALL never wrap.
REQ-021 The block SHALL contain no combinational path from sw_i to any output.

Reset
REQ-022 While reset is high at an edge: s1, s2, sw_o, counters, rise_o, fall_o and chg_o SHALL all be 0, and every FSM SHALL be in STABLE.
REQ-023 Reset asserted mid-count SHALL abort that count; no pulse SHALL be emitted.
REQ-024 After release, switches already high SHALL be accepted per REQ-016, counting from the first post-reset edge, and SHALL generate rise_o pulses.

Structure
REQ-025 Shared package gpio_pkg SHALL hold GPIO_WIDTH (8), DB_CYCLES_DEFAULT (500000) and the STABLE/PENDING state enum.
REQ-026 Per-bit logic (synchroniser, counter, FSM, edge pulses) SHALL be sub-module debounce_bit, instantiated WIDTH times by a generate loop.
REQ-027 The top level SHALL contain only the generate loop and the chg_o reduction register.

Verification (DB_CYCLES=4, WIDTH=8)
REQ-028 Hold sw_i=0x01 from edge k -> sw_o=0x01 at edge k+5; rise_o=0x01 and chg_o=1 for exactly that one cycle.
REQ-029 Pulse sw_i[0] high for 3 cycles, then low -> sw_o stays 0x00; no rise_o, fall_o or chg_o activity.
REQ-030 Apply sw_i 0x00->0x81 at edge k, then 0x81->0x80 at edge k+20 -> sw_o=0x81 at k+5 with rise_o=0x81 and a single chg_o; sw_o=0x80 at k+25 with fall_o=0x01.
REQ-031 Hold sw_i=0xFF, assert reset at edge k+3 for one cycle -> all outputs 0 during reset; sw_o=0xFF exactly 5 edges after the first post-reset sampling edge, with rise_o=0xFF.
REQ-032 Bounce sw_i[2] with 1,1,1,0,1,1,1,1 (one sample per edge) -> counter clears at the 0, restarts, and sw_o[2]=1 is accepted only after 4 consecutive high cycles at s2.
